// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame layout constants and the receiver state encoding.
// The transmitter uses the same frame constants so that both ends agree on the frame shape.
package uart_rx_pkg;

   localparam int data_bits  = 8;
   localparam int start_bits = 1;
   localparam int stop_bits  = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_e;

   // Mid-bit offset in clock cycles; rounds down for odd bit lengths.
   function automatic int half_bit(input int cycles_per_bit);
      return cycles_per_bit / 2;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects the falling edge of the start bit, re-checks it at
// mid-bit to reject glitches, then samples each data bit and the stop bit one
// bit period apart. Good bytes are strobed out and accumulated into a 32-bit
// running sum; a low stop bit produces a framing-error strobe and the receiver
// waits for the line to return high before hunting for the next start bit.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int cycles_per_bit = 4
) (
   input  logic        clock,
   input  logic        tick_i_rstn,
   input  logic        tick_i_serial,
   output logic        valid_ret,
   output logic [7:0]  data_ret,
   output logic [31:0] sum_ret,
   output logic        frame_err_ret
);

   localparam int half      = half_bit(cycles_per_bit);
   localparam int cw_raw    = $clog2(cycles_per_bit);
   localparam int cw        = (cw_raw > 1) ? cw_raw : 1;

   localparam logic [cw-1:0] cycle_full  = cw'(cycles_per_bit - 1);
   localparam logic [cw-1:0] cycle_half  = cw'(half - 1);
   localparam logic [cw-1:0] cycle_zero  = '0;
   localparam logic [3:0]    cursor_last = 4'(data_bits - 1);

   uart_state_e   state;
   logic [cw-1:0] cycle;
   logic [3:0]    cursor;
   logic [7:0]    buffer;

   // Frame sequencer: counts bit periods, samples the line at mid-bit and issues the output strobes.
   always_ff @(posedge clock) begin
      if (!tick_i_rstn) begin
         state         <= IDLE;
         cycle         <= '0;
         cursor        <= '0;
         buffer        <= '0;
         data_ret      <= '0;
         sum_ret       <= '0;
         valid_ret     <= 1'b0;
         frame_err_ret <= 1'b0;
      end else begin
         valid_ret     <= 1'b0;
         frame_err_ret <= 1'b0;

         case (state)
            IDLE: begin
               cursor <= '0;
               if (!tick_i_serial) begin
                  state <= START;
                  cycle <= cycle_half;
               end
            end

            START: begin
               if (cycle != cycle_zero) begin
                  cycle <= cycle - 1'b1;
               end else if (!tick_i_serial) begin
                  state  <= DATA;
                  cycle  <= cycle_full;
                  cursor <= '0;
               end else begin
                  state <= IDLE;
               end
            end

            DATA: begin
               if (cycle != cycle_zero) begin
                  cycle <= cycle - 1'b1;
               end else begin
                  buffer <= {tick_i_serial, buffer[7:1]};
                  cycle  <= cycle_full;
                  cursor <= cursor + 4'd1;
                  if (cursor == cursor_last) begin
                     state <= STOP;
                  end
               end
            end

            STOP: begin
               if (cycle != cycle_zero) begin
                  cycle <= cycle - 1'b1;
               end else if (tick_i_serial) begin
                  valid_ret <= 1'b1;
                  data_ret  <= buffer;
                  sum_ret   <= sum_ret + {24'd0, buffer};
                  state     <= IDLE;
               end else begin
                  frame_err_ret <= 1'b1;
                  state         <= BREAK;
               end
            end

            BREAK: begin
               if (tick_i_serial) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at cycles_per_bit=4: a table of whole frames with
// hand-computed results, followed by hand-written timing, glitch, break, reset and
// full-byte-range loopback sequences.
module tb_uart_rx;

   localparam int cpb  = 4;
   localparam int half = cpb / 2;

   logic        clock;
   logic        tick_i_rstn;
   logic        tick_i_serial;
   logic        valid_ret;
   logic [7:0]  data_ret;
   logic [31:0] sum_ret;
   logic        frame_err_ret;

   int checks;
   int errors;
   int cycle_count;
   int valid_count;
   int err_count;
   int last_valid_cycle;
   int prev_valid_cycle;
   int stretch_count;
   int both_count;
   int frame_start;
   logic valid_prev;
   logic err_prev;

   typedef struct {
      logic        do_reset;
      logic [7:0]  value;
      logic        stop_bit;
      int          idle_bits;
      int          exp_valid;
      int          exp_err;
      logic [7:0]  exp_data;
      logic [31:0] exp_sum;
   } vec_t;

   vec_t vectors[6];

   uart_rx #(.cycles_per_bit(cpb)) dut (
      .clock         (clock),
      .tick_i_rstn   (tick_i_rstn),
      .tick_i_serial (tick_i_serial),
      .valid_ret     (valid_ret),
      .data_ret      (data_ret),
      .sum_ret       (sum_ret),
      .frame_err_ret (frame_err_ret)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Counts rising edges so strobe timing can be compared against frame start.
   always @(posedge clock) begin
      cycle_count = cycle_count + 1;
   end

   // Observes outputs on the falling edge: counts strobes and flags stretched or overlapping strobes.
   always @(negedge clock) begin
      if (valid_ret) begin
         valid_count      = valid_count + 1;
         prev_valid_cycle = last_valid_cycle;
         last_valid_cycle = cycle_count;
         if (valid_prev) stretch_count = stretch_count + 1;
      end
      if (frame_err_ret) begin
         err_count = err_count + 1;
         if (err_prev) stretch_count = stretch_count + 1;
      end
      if (valid_ret && frame_err_ret) both_count = both_count + 1;
      valid_prev = valid_ret;
      err_prev   = frame_err_ret;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic driveBit(input logic b);
      tick_i_serial = b;
      repeat (cpb) @(negedge clock);
   endtask

   task automatic idleBits(input int n);
      repeat (n) driveBit(1'b1);
   endtask

   // Sends one frame; must be called on a falling edge. The line is left at the last stop-bit level.
   task automatic applyStimulus(input logic [7:0] value, input logic stop_bit, input int stop_count);
      frame_start = cycle_count + 1;
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(value[i]);
      for (int i = 0; i < stop_count; i++) driveBit(stop_bit);
   endtask

   task automatic applyReset();
      @(negedge clock);
      tick_i_rstn = 1'b0;
      @(negedge clock);
      tick_i_rstn = 1'b1;
   endtask

   initial begin
      int v0;
      int e0;
      logic [31:0] sum_model;

      checks           = 0;
      errors           = 0;
      cycle_count      = 0;
      valid_count      = 0;
      err_count        = 0;
      last_valid_cycle = 0;
      prev_valid_cycle = 0;
      stretch_count    = 0;
      both_count       = 0;
      frame_start      = 0;
      valid_prev       = 1'b0;
      err_prev         = 1'b0;
      tick_i_rstn      = 1'b0;
      tick_i_serial    = 1'b1;

      vectors[0] = '{1'b1, 8'h55, 1'b1, 2, 1, 0, 8'h55, 32'h0000_0055};
      vectors[1] = '{1'b1, 8'h01, 1'b1, 0, 1, 0, 8'h01, 32'h0000_0001};
      vectors[2] = '{1'b0, 8'hFF, 1'b1, 2, 1, 0, 8'hFF, 32'h0000_0100};
      vectors[3] = '{1'b0, 8'h3C, 1'b0, 2, 0, 1, 8'hFF, 32'h0000_0100};
      vectors[4] = '{1'b0, 8'h11, 1'b1, 1, 1, 0, 8'h11, 32'h0000_0111};
      vectors[5] = '{1'b0, 8'h80, 1'b1, 1, 1, 0, 8'h80, 32'h0000_0191};

      // Power-up reset state
      repeat (3) @(negedge clock);
      checkOutput("reset_valid", {31'd0, valid_ret}, 32'd0);
      checkOutput("reset_err",   {31'd0, frame_err_ret}, 32'd0);
      checkOutput("reset_data",  {24'd0, data_ret}, 32'd0);
      checkOutput("reset_sum",   sum_ret, 32'd0);
      tick_i_rstn = 1'b1;
      idleBits(2);

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         if (vectors[i].do_reset) begin
            applyReset();
            idleBits(1);
         end
         v0 = valid_count;
         e0 = err_count;
         applyStimulus(vectors[i].value, vectors[i].stop_bit, 1);
         idleBits(vectors[i].idle_bits);
         checkOutput($sformatf("vec%0d_valid_cnt", i), 32'(valid_count - v0), 32'(vectors[i].exp_valid));
         checkOutput($sformatf("vec%0d_err_cnt", i), 32'(err_count - e0), 32'(vectors[i].exp_err));
         checkOutput($sformatf("vec%0d_data", i), {24'd0, data_ret}, {24'd0, vectors[i].exp_data});
         checkOutput($sformatf("vec%0d_sum", i), sum_ret, vectors[i].exp_sum);
      end

      // Single 0x55 frame: strobe latency from start detection
      applyReset();
      idleBits(1);
      v0 = valid_count;
      applyStimulus(8'h55, 1'b1, 1);
      idleBits(1);
      checkOutput("latency_55", 32'(last_valid_cycle - frame_start), 32'(half + 9 * cpb));
      checkOutput("latency_55_cnt", 32'(valid_count - v0), 32'd1);

      // Back-to-back frames with a single stop bit
      applyReset();
      idleBits(1);
      applyStimulus(8'h01, 1'b1, 1);
      applyStimulus(8'hFF, 1'b1, 1);
      idleBits(1);
      checkOutput("b2b_spacing", 32'(last_valid_cycle - prev_valid_cycle), 32'(10 * cpb));
      checkOutput("b2b_sum", sum_ret, 32'h0000_0100);

      // Glitch: one low cycle is rejected, the next frame is received
      v0 = valid_count;
      e0 = err_count;
      tick_i_serial = 1'b0;
      @(negedge clock);
      tick_i_serial = 1'b1;
      repeat (50) @(negedge clock);
      checkOutput("glitch_no_valid", 32'(valid_count - v0), 32'd0);
      checkOutput("glitch_no_err", 32'(err_count - e0), 32'd0);
      applyStimulus(8'hA5, 1'b1, 1);
      idleBits(1);
      checkOutput("glitch_next_data", {24'd0, data_ret}, 32'h0000_00A5);
      checkOutput("glitch_next_sum", sum_ret, 32'h0000_01A5);

      // Framing error followed by a held-low break
      applyReset();
      idleBits(1);
      applyStimulus(8'h20, 1'b1, 1);
      idleBits(1);
      v0 = valid_count;
      e0 = err_count;
      applyStimulus(8'h3C, 1'b0, 1);
      tick_i_serial = 1'b0;
      repeat (20) @(negedge clock);
      checkOutput("ferr_err_cnt", 32'(err_count - e0), 32'd1);
      checkOutput("ferr_no_valid", 32'(valid_count - v0), 32'd0);
      checkOutput("ferr_data_held", {24'd0, data_ret}, 32'h0000_0020);
      checkOutput("ferr_sum_held", sum_ret, 32'h0000_0020);
      idleBits(2);
      applyStimulus(8'h11, 1'b1, 1);
      idleBits(1);
      checkOutput("ferr_next_data", {24'd0, data_ret}, 32'h0000_0011);
      checkOutput("ferr_next_sum", sum_ret, 32'h0000_0031);
      checkOutput("ferr_err_total", 32'(err_count - e0), 32'd1);

      // Reset during data bit 4 abandons the frame
      applyStimulus(8'h42, 1'b1, 1);
      idleBits(1);
      driveBit(1'b0);
      for (int i = 0; i < 4; i++) driveBit(i[0]);
      tick_i_serial = 1'b0;
      @(negedge clock);
      v0 = valid_count;
      e0 = err_count;
      tick_i_rstn   = 1'b0;
      tick_i_serial = 1'b1;
      @(negedge clock);
      checkOutput("midrst_valid", {31'd0, valid_ret}, 32'd0);
      checkOutput("midrst_err",   {31'd0, frame_err_ret}, 32'd0);
      checkOutput("midrst_data",  {24'd0, data_ret}, 32'd0);
      checkOutput("midrst_sum",   sum_ret, 32'd0);
      tick_i_rstn = 1'b1;
      idleBits(12);
      checkOutput("midrst_no_strobe", 32'(valid_count - v0 + err_count - e0), 32'd0);
      applyStimulus(8'h7E, 1'b1, 1);
      idleBits(1);
      checkOutput("midrst_next_data", {24'd0, data_ret}, 32'h0000_007E);
      checkOutput("midrst_next_sum", sum_ret, 32'h0000_007E);
      checkOutput("midrst_next_cnt", 32'(valid_count - v0), 32'd1);

      // Loopback-style sweep of every byte value, mixing one and two stop bits
      applyReset();
      idleBits(1);
      v0 = valid_count;
      e0 = err_count;
      sum_model = 32'd0;
      for (int b = 0; b < 256; b++) begin
         applyStimulus(8'(b), 1'b1, ((b % 3) == 0) ? 2 : 1);
         @(negedge clock);
         sum_model = sum_model + 32'(b);
         checkOutput($sformatf("loop_data_%0d", b), {24'd0, data_ret}, 32'(b));
         if (sum_ret !== sum_model) checkOutput($sformatf("loop_sum_%0d", b), sum_ret, sum_model);
      end
      idleBits(1);
      checkOutput("loop_valid_cnt", 32'(valid_count - v0), 32'd256);
      checkOutput("loop_err_cnt", 32'(err_count - e0), 32'd0);
      checkOutput("loop_sum", sum_ret, 32'h0000_7F80);

      // Strobe shape over the whole run
      checkOutput("strobe_width", 32'(stretch_count), 32'd0);
      checkOutput("strobe_overlap", 32'(both_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the 8N1 UART link; the receive end of the existing uart_tx transmitter (1 start bit, 8 data bits LSB first, stop bit(s) idle-high).
- Samples the line at mid-bit using the same cycles_per_bit timing as the transmitter.
- Emits each received byte with a one-cycle valid strobe and keeps a running 32-bit sum of good bytes, used as a loopback checksum in the uart example top level.
- Detects framing errors and recovers cleanly from glitches.

Parameters:
- cycles_per_bit, 4: clock cycles per serial bit. Must match uart_tx. Legal range is 2 or more. H = cycles_per_bit/2, rounded down.

Ports:
- clock  input  1  global clock, rising edge.
- tick_i_rstn  input  1  synchronous reset, active-low.
- tick_i_serial  input  1  serial line, idle high. Already synchronised upstream.
- valid_ret  output  1  one-cycle strobe: new good byte on data_ret.
- data_ret  output  8  last good byte received. Holds its value between strobes.
- sum_ret  output  32  running sum of all good bytes, modulo 2^32.
- frame_err_ret  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Reset, when tick_i_rstn=0 at a clock edge:
  - state=IDLE, all counters 0.
  - data_ret=0, sum_ret=0, valid_ret=0, frame_err_ret=0.
  - Reset has priority over everything. If reset arrives mid-frame, the frame is abandoned with no strobe, and reception resumes from IDLE.
- All outputs are registered. No combinational path from tick_i_serial to any output.
- State machine states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - Sampling tick_i_serial=0 at edge k marks start detection.
  - Transition to START and load cycle=H-1.
- START:
  - cycle counts down to 0, so the re-sample lands at edge k+H.
  - At cycle==0, sample the line:
    - Line is 0: go to DATA with cycle=cycles_per_bit-1 and cursor=0.
    - Line is 1: false start (glitch). Return to IDLE with no strobe.
- DATA:
  - At each cycle==0, shift the sampled bit into a buffer MSB, shifting right (LSB-first reception).
  - Reload cycle=cycles_per_bit-1 and increment cursor.
  - Data bit i is sampled at edge k+H+(i+1)*cycles_per_bit, for i=0..7.
  - After bit 7 (cursor reaches 8), go to STOP with cycle=cycles_per_bit-1.
- STOP: the stop bit is sampled at edge k+H+9*cycles_per_bit.
  - Line is 1:
    - Next cycle: valid_ret=1, data_ret=buffer, sum_ret=sum_ret+buffer (32-bit wrap).
    - Return to IDLE.
  - Line is 0:
    - Next cycle: frame_err_ret=1. data_ret and sum_ret are unchanged.
    - Go to BREAK.
- BREAK: wait until the line samples 1, then go to IDLE. A held-low line (break condition) produces no further strobes.
- Strobe timing:
  - valid_ret and frame_err_ret are each high for exactly one cycle.
  - They are never high together.
  - Each is deasserted on the cycle after it was asserted.
- Back-to-back frames:
  - IDLE is re-entered in the same cycle the strobe is driven.
  - A start bit beginning immediately after a single stop bit is detected.
  - uart_tx's extra stop bits are tolerated; they look like idle.
- Width rules:
  - cycle counter width is max(1,$clog2(cycles_per_bit)). cursor is 4 bits.
  - Counter loads use explicit width casts. No implicit truncation.

Decomposition:
- Shared uart package holds:
  - Frame constants: data_bits=8, start_bits=1, stop_bits=1.
  - The state enum: IDLE, START, DATA, STOP, BREAK.
- uart_tx reuses the same frame constants.
- Single flat module. No sub-module is natural at this size.

Test Plan (cycles_per_bit=4, H=2):
- Single byte: drive the 10-bit frame for 0x55 from idle high. Expect valid_ret high for exactly 1 cycle at edge k+2+36+1, data_ret=0x55, sum_ret=0x55, frame_err_ret never high.
- Back-to-back: frames 0x01 then 0xFF, one stop bit each. Expect two valid strobes 40 cycles apart and final sum_ret=0x100.
- Glitch: line low for 1 cycle, then high for 50 cycles. Expect no strobes, state returns to IDLE, and a following 0xA5 frame is received correctly.
- Framing error: 0x3C frame with stop bit 0, then line held low 20 cycles, then high, then a 0x11 frame. Expect frame_err_ret 1 cycle, data_ret and sum_ret unchanged, then valid with data_ret=0x11.
- Reset mid-frame: assert tick_i_rstn=0 for 1 cycle during data bit 4, then send 0x7E. Expect all outputs 0 after reset, no strobe for the aborted frame, then valid with data_ret=0x7E and sum_ret=0x7E.
- Loopback: connect uart_tx serial_ret to tick_i_serial and send all 256 byte values. Expect 256 valid strobes, bytes match in order, sum_ret=0x7F80, zero frame errors.
